// File: rtl/interrupt_request_latch.sv
// rtl/interrupt_request_latch.sv - synchronise, edge-detect and latch interrupt requests ahead of the priority encoder
//
// Ports:
//   clock            system clock, all state updates on the rising edge
//   reset            synchronous, active-high; wins over every other input
//   externalRequests asynchronous level lines; each rising edge is one request
//   internalRequests synchronous one-cycle request pulses from the CPU core
//   ackValid         one-cycle pulse: interrupt ackNumber entered service
//   ackNumber        index being acknowledged (ignored when >= WIDTH)
//   overrunClear     one-cycle pulse: clears all overrun bits
//   externalPending  latched external requests (to encoder externalInterrupts)
//   internalPending  latched internal requests (to encoder internalInterrupts)
//   overrun          sticky: external edge arrived while that line was already pending
//   anyPending       OR of both pending vectors, taken straight from the registers
module interrupt_request_latch #(
    parameter int WIDTH        = 16,
    parameter int NUMBER_WIDTH = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [WIDTH-1:0]        externalRequests,
    input  logic [WIDTH-1:0]        internalRequests,
    input  logic                    ackValid,
    input  logic [NUMBER_WIDTH-1:0] ackNumber,
    input  logic                    overrunClear,
    output logic [WIDTH-1:0]        externalPending,
    output logic [WIDTH-1:0]        internalPending,
    output logic [WIDTH-1:0]        overrun,
    output logic                    anyPending
);

    // One extra bit so WIDTH == 2**NUMBER_WIDTH still compares correctly.
    localparam logic [NUMBER_WIDTH:0] line_count = (NUMBER_WIDTH+1)'(WIDTH);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] prev;

    logic [WIDTH-1:0] rise;
    logic             ack_in_range;
    logic [WIDTH-1:0] ack_onehot;
    logic             ack_hits_internal;
    logic [WIDTH-1:0] internal_clear;
    logic [WIDTH-1:0] external_clear;
    logic [WIDTH-1:0] external_kept;
    logic [WIDTH-1:0] overrun_event;

    always_comb begin
        rise         = sync2 & ~prev;
        ack_in_range = ackValid && ({1'b0, ackNumber} < line_count);
        ack_onehot   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            ack_onehot[i] = ack_in_range && (ackNumber == NUMBER_WIDTH'(i));
        end
        // Internal lines are serviced ahead of external ones, matching the
        // encoder, so an ack clears the internal bit when one is pending.
        ack_hits_internal = |(internalPending & ack_onehot);
        internal_clear    = ack_hits_internal ? ack_onehot : '0;
        external_clear    = ack_hits_internal ? '0 : ack_onehot;
        external_kept     = externalPending & ~external_clear;
        // A new edge on a line that stays pending this cycle is a lost request.
        overrun_event     = rise & external_kept;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1           <= '0;
            sync2           <= '0;
            prev            <= '0;
            externalPending <= '0;
            internalPending <= '0;
            overrun         <= '0;
        end else begin
            sync1           <= externalRequests;
            sync2           <= sync1;
            prev            <= sync2;
            // Set terms are OR'd after the clear so a new request beats an ack.
            externalPending <= external_kept | rise;
            internalPending <= (internalPending & ~internal_clear) | internalRequests;
            overrun         <= (overrunClear ? '0 : overrun) | overrun_event;
        end
    end

    assign anyPending = (|externalPending) | (|internalPending);

endmodule

// File: tb/tb_interrupt_request_latch.sv
// tb/tb_interrupt_request_latch.sv - self-checking bench for interrupt_request_latch
module tb_interrupt_request_latch;

    localparam int W  = 12;
    localparam int NW = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic [W-1:0]  externalRequests;
    logic [W-1:0]  internalRequests;
    logic          ackValid;
    logic [NW-1:0] ackNumber;
    logic          overrunClear;
    logic [W-1:0]  externalPending;
    logic [W-1:0]  internalPending;
    logic [W-1:0]  overrun;
    logic          anyPending;

    int compared   = 0;
    int mismatched = 0;

    // Reference state: pending/overrun sets plus the last three sampled input values.
    logic [W-1:0] m_ep, m_ip, m_ov;
    logic [W-1:0] hist [3];

    always #5 clock = ~clock;

    interrupt_request_latch #(.WIDTH(W), .NUMBER_WIDTH(NW)) dut (
        .clock(clock),
        .reset(reset),
        .externalRequests(externalRequests),
        .internalRequests(internalRequests),
        .ackValid(ackValid),
        .ackNumber(ackNumber),
        .overrunClear(overrunClear),
        .externalPending(externalPending),
        .internalPending(internalPending),
        .overrun(overrun),
        .anyPending(anyPending)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // A request is seen when the line was low three samples ago and high two
    // samples ago; an ack removes one request, internal first.
    task automatic model_edge();
        logic [W-1:0] rise, ep, ip;
        int k;
        if (reset) begin
            m_ep = '0; m_ip = '0; m_ov = '0;
            hist[0] = '0; hist[1] = '0; hist[2] = '0;
        end else begin
            rise = hist[1] & ~hist[2];
            ep = m_ep;
            ip = m_ip;
            k = int'(ackNumber);
            if (ackValid && k < W) begin
                if (ip[k]) ip[k] = 1'b0;
                else       ep[k] = 1'b0;
            end
            m_ov = (overrunClear ? '0 : m_ov) | (rise & ep);
            m_ep = ep | rise;
            m_ip = ip | internalRequests;
            hist[2] = hist[1];
            hist[1] = hist[0];
            hist[0] = externalRequests;
        end
    endtask

    task automatic step();
        @(posedge clock);
        model_edge();
        #1;
        chk("externalPending", 16'(externalPending), 16'(m_ep));
        chk("internalPending", 16'(internalPending), 16'(m_ip));
        chk("overrun",         16'(overrun),         16'(m_ov));
        chk("anyPending",      16'(anyPending),      16'((m_ep != '0) || (m_ip != '0)));
    endtask

    task automatic idle();
        internalRequests = '0;
        ackValid = 1'b0;
        ackNumber = '0;
        overrunClear = 1'b0;
        reset = 1'b0;
    endtask

    initial begin
        m_ep = '0; m_ip = '0; m_ov = '0;
        hist[0] = '0; hist[1] = '0; hist[2] = '0;
        externalRequests = '0;
        idle();
        reset = 1'b1;
        step();
        step();
        chk("reset_pending", 16'(externalPending | internalPending), 16'h0000);
        reset = 1'b0;

        // 1: external rising edge, three-clock latency, held level gives no overrun
        externalRequests = 12'h008;
        step();
        chk("ext_latency_e1", 16'(externalPending), 16'h0000);
        step();
        chk("ext_latency_e2", 16'(externalPending), 16'h0000);
        step();
        chk("ext_pending_e3", 16'(externalPending), 16'h0008);
        chk("ext_any",        16'(anyPending),      16'h0001);
        repeat (4) step();
        chk("held_no_overrun", 16'(overrun), 16'h0000);
        ackValid = 1'b1; ackNumber = 4'd3;
        step();
        idle();
        externalRequests = '0;
        step();

        // 2: internal request and ack
        internalRequests = 12'h020;
        step();
        chk("int_set", 16'(internalPending), 16'h0020);
        idle();
        ackValid = 1'b1; ackNumber = 4'd5;
        step();
        chk("int_ack", 16'(internalPending), 16'h0000);
        idle();

        // 3: internal serviced before external on the same bit
        externalRequests = 12'h004;
        internalRequests = 12'h004;
        step();
        idle();
        step();
        step();
        chk("both_ext", 16'(externalPending), 16'h0004);
        chk("both_int", 16'(internalPending), 16'h0004);
        ackValid = 1'b1; ackNumber = 4'd2;
        step();
        chk("ack1_int", 16'(internalPending), 16'h0000);
        chk("ack1_ext", 16'(externalPending), 16'h0004);
        step();
        chk("ack2_ext", 16'(externalPending), 16'h0000);
        idle();

        // 4: overrun on a second edge before service, then clear
        externalRequests = 12'h084;
        repeat (3) step();
        externalRequests = 12'h004;
        repeat (2) step();
        externalRequests = 12'h084;
        repeat (3) step();
        chk("overrun_set", 16'(overrun), 16'h0080);
        chk("overrun_pend", 16'(externalPending), 16'h0080);
        overrunClear = 1'b1;
        step();
        chk("overrun_clr", 16'(overrun), 16'h0000);
        idle();

        // 5: set beats ack on the same bit; out-of-range ack ignored
        internalRequests = 12'h200;
        ackValid = 1'b1; ackNumber = 4'd9;
        step();
        chk("set_wins", 16'(internalPending), 16'h0200);
        idle();
        ackValid = 1'b1; ackNumber = 4'd15;
        step();
        chk("ack15_int", 16'(internalPending), 16'h0200);
        chk("ack15_ext", 16'(externalPending), 16'h0080);
        idle();

        // 6: reset with bits pending and ext[0] mid-sync
        externalRequests = 12'h085;
        step();
        reset = 1'b1;
        step();
        chk("rst_ext", 16'(externalPending), 16'h0000);
        chk("rst_int", 16'(internalPending), 16'h0000);
        chk("rst_any", 16'(anyPending),      16'h0000);
        reset = 1'b0;
        externalRequests = 12'h001;
        step();
        step();
        chk("post_rst_e2", 16'(externalPending), 16'h0000);
        step();
        chk("post_rst_e3", 16'(externalPending), 16'h0001);
        repeat (3) step();
        chk("post_rst_once", 16'(overrun), 16'h0000);

        // Randomised traffic against the reference model
        for (int n = 0; n < 600; n++) begin
            externalRequests = externalRequests ^ W'($urandom & $urandom & $urandom);
            internalRequests = W'($urandom & $urandom & $urandom & $urandom);
            ackValid         = 1'($urandom);
            ackNumber        = NW'($urandom);
            overrunClear     = ($urandom_range(0, 15) == 0);
            reset            = ($urandom_range(0, 99) == 0);
            step();
        end
        idle();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
